ra_bist_chk: RTL and testbench
==============================

Name: ra_bist_chk

Overview:
- Response analyser on the return side of the array BIST path.
- The BIST sequencer issues reads to the 64x72 two-read/one-write array. For each issued read, this block receives a tag: port, address and expected-pattern code.
- After the array read latency, it compares the returned rd0_dat/rd1_dat against the regenerated expected word.
- Accumulates sticky pass/fail, a saturating fail count and first-fail diagnostics, and packs them into the 32-bit status word.

Parameters:
- GENMODE, `GENMODE: 0=NoDelay, 1=Delay. Passed through; no behavioural effect.
- RD_LAT, 1: cycles from read enable to valid read data. Legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears all results and enters RUN.
- done  in  1  one-cycle pulse; the sequencer has issued its last read.
- phase  in  3  march-element index of the current reads; captured on first fail.
- rd0_chk  in  1  a read was issued on port 0 this cycle and must be checked.
- rd0_adr  in  6  port 0 read address.
- rd0_pat  in  2  port 0 expected pattern: 00=all 0, 01=all 1, 10=checkerboard, 11=inverse checkerboard.
- rd0_dat  in  72  port 0 array read data.
- rd1_chk  in  1  as rd0_chk, for port 1.
- rd1_adr  in  6  as rd0_adr, for port 1.
- rd1_pat  in  2  as rd0_pat, for port 1.
- rd1_dat  in  72  as rd0_dat, for port 1.
- busy  out  1  state is RUN or DRAIN.
- bist_fail  out  1  sticky; at least one mismatch since start.
- bist_passed  out  1  state is DONE and no mismatch occurred.
- fail_cnt  out  8  saturating count of mismatching reads.
- ff_port  out  1  port of the first failure.
- ff_adr  out  6  address of the first failure.
- ff_phase  out  3  phase of the first failure.
- ff_bit  out  7  lowest mismatching bit index of the first failure.
- status  out  32  packed result word.

Behaviour:
- Reset values: state IDLE; all outputs 0; tag pipelines cleared. A reset during any operation returns to IDLE immediately.
- State IDLE:
  - start goes to RUN.
  - chk inputs are ignored; nothing is enqueued.
- State RUN:
  - Tags are enqueued each cycle.
  - done goes to DRAIN. Tags presented in the same cycle as done are still enqueued.
- State DRAIN:
  - New chk inputs are ignored.
  - After exactly RD_LAT cycles the state goes to DONE, so the last tag is compared.
- State DONE:
  - Results are held.
  - start goes to RUN.
- start in any state:
  - Clears fail, fail_cnt and ff_* at the next edge, flushes the tag pipeline and enters RUN.
  - start takes priority over a simultaneous done.
- Tag pipeline: per port, {chk, adr, pat} delayed by RD_LAT registers. A tag with chk at edge N is compared at cycle N+RD_LAT against rd*_dat sampled at that cycle.
- Expected word for bit i:
  - pat 00: 0.
  - pat 01: 1.
  - pat 10: i[0] XOR adr[0].
  - pat 11: NOT(i[0] XOR adr[0]).
  - Example: odd address, pat 10 gives 72'h555555555555555555; even address gives 72'hAAAAAAAAAAAAAAAAAA.
- Mismatch = delayed chk AND (rd_dat != expected). All flags are registered, so a mismatch compared at cycle C is visible on outputs at C+1.
- fail_cnt increments by the number of mismatching ports in the cycle (0, 1 or 2) and saturates at 255; it never wraps.
- First fail: ff_* are captured only while bist_fail is 0.
  - If both ports fail in the same cycle, port 0 wins.
  - ff_bit is the lowest mismatching bit index (0..71).
  - ff_phase is the phase value delayed alongside the tag.
- bist_fail is sticky until start or reset. bist_passed = (state==DONE) AND NOT bist_fail.
- status bit map:
  - [31] busy, [30] bist_passed, [29] bist_fail, [28] ff_port.
  - [27:25] ff_phase, [24:19] ff_adr, [18:12] ff_bit.
  - [11:4] fail_cnt, [3:0] 0.

Decomposition:
- Shared package (header):
  - Pattern codes PAT_ZERO=0, PAT_ONE=1, PAT_CB=2, PAT_ICB=3.
  - State encodings IDLE/RUN/DRAIN/DONE.
  - Status field bit positions.
  - Widths ADR_W=6, DAT_W=72.
- One sub-module: ra_bist_chk_pipe, a parameterised RD_LAT-deep delay line for {chk, adr, pat, phase} with a flush input. It is instantiated once per port.

Test Plan:
1. Reset, start, then 64 rd0_chk reads with pat 00 and rd0_dat=0, then done. With RD_LAT=1, bist_passed=1 two cycles after done; bist_fail=0; fail_cnt=0; status=32'h4000_0000.
2. pat 01, phase=3; at address 0x2A, rd0_dat has bit 17 cleared. bist_fail=1 at cycle N+RD_LAT+1; ff_adr=0x2A, ff_bit=17, ff_port=0, ff_phase=3, fail_cnt=1. bist_passed stays 0 after done.
3. In the same cycle, rd0 fails at address 5 and rd1 fails at address 9; a later failure follows at address 0x10. Result: ff_port=0, ff_adr=5, fail_cnt=3.
4. pat 10: address 0x01 returns 72'h55..5 and address 0x02 returns 72'hAA..A, so no fail. Then pat 11 at address 0x01 returning 72'h55..5 fails with ff_bit=0.
5. 300 consecutive failing reads on both ports: fail_cnt reaches 255 and holds there.
6. Mid-RUN with fail set, assert start: next cycle status=32'h8000_0000. Separately, assert reset mid-DRAIN: all outputs are 0 and chk pulses in IDLE produce no fail.

Source files
------------

// File: rtl/ra_bist_chk_pkg.sv
// Shared types, widths, status layout and expected-pattern helpers for the
// array BIST response analyser.
package ra_bist_chk_pkg;

  localparam int ADR_W = 6;
  localparam int DAT_W = 72;
  localparam int PH_W  = 3;
  localparam int BIT_W = 7;
  localparam int CNT_W = 8;

  localparam logic [1:0] PAT_ZERO = 2'd0;
  localparam logic [1:0] PAT_ONE  = 2'd1;
  localparam logic [1:0] PAT_CB   = 2'd2;
  localparam logic [1:0] PAT_ICB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int STS_BUSY    = 31;
  localparam int STS_PASS    = 30;
  localparam int STS_FAIL    = 29;
  localparam int STS_PORT    = 28;
  localparam int STS_PH_LSB  = 25;
  localparam int STS_ADR_LSB = 19;
  localparam int STS_BIT_LSB = 12;
  localparam int STS_CNT_LSB = 4;

  typedef struct packed {
    logic             chk;
    logic [ADR_W-1:0] adr;
    logic [1:0]       pat;
    logic [PH_W-1:0]  phase;
  } tag_t;

  // Checkerboard bit i is i[0] XOR adr[0]; even address yields 0xAA..A.
  function automatic logic [DAT_W-1:0] exp_word(input logic [1:0] pat,
                                                input logic [ADR_W-1:0] adr);
    logic [DAT_W-1:0] cb;
    cb = adr[0] ? {36{2'b01}} : {36{2'b10}};
    case (pat)
      PAT_ZERO: return {DAT_W{1'b0}};
      PAT_ONE:  return {DAT_W{1'b1}};
      PAT_CB:   return cb;
      default:  return ~cb;
    endcase
  endfunction

  function automatic logic [BIT_W-1:0] low_bit(input logic [DAT_W-1:0] v);
    logic [BIT_W-1:0] r;
    r = 7'd0;
    for (int i = DAT_W - 1; i >= 0; i--) begin
      if (v[i]) r = BIT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ra_bist_chk_pipe.sv
// Read-latency delay line for one port's check tag; flush empties every stage.
module ra_bist_chk_pipe
  import ra_bist_chk_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [LAT];

  // Shift tags one stage per cycle; reset or flush clears all stages.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/ra_bist_chk.sv
// BIST response analyser: compares delayed read tags against returned data and
// accumulates sticky pass/fail, saturating fail count and first-fail details.
module ra_bist_chk
  import ra_bist_chk_pkg::*;
#(
  parameter int GENMODE = 0,
  parameter int RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic [PH_W-1:0]  phase,
  input  logic             rd0_chk,
  input  logic [ADR_W-1:0] rd0_adr,
  input  logic [1:0]       rd0_pat,
  input  logic [DAT_W-1:0] rd0_dat,
  input  logic             rd1_chk,
  input  logic [ADR_W-1:0] rd1_adr,
  input  logic [1:0]       rd1_pat,
  input  logic [DAT_W-1:0] rd1_dat,
  output logic             busy,
  output logic             bist_fail,
  output logic             bist_passed,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_port,
  output logic [ADR_W-1:0] ff_adr,
  output logic [PH_W-1:0]  ff_phase,
  output logic [BIT_W-1:0] ff_bit,
  output logic [31:0]      status
);

  // GENMODE only selects array timing elsewhere; the latency is all that matters here.
  localparam int LAT = (GENMODE >= 0) ? RD_LAT : RD_LAT;

  state_e           state_q, state_d;
  logic [1:0]       drn_q, drn_d;
  logic             busy_q, busy_d, pass_q, pass_d, fail_q, fail_d, port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  tag_t             tag0_in, tag1_in, tag0, tag1;
  logic [DAT_W-1:0] diff0, diff1;
  logic             mis0, mis1;
  logic [CNT_W:0]   sum;

  assign tag0_in = '{chk: rd0_chk && (state_q == ST_RUN), adr: rd0_adr, pat: rd0_pat, phase: phase};
  assign tag1_in = '{chk: rd1_chk && (state_q == ST_RUN), adr: rd1_adr, pat: rd1_pat, phase: phase};

  ra_bist_chk_pipe #(.LAT(LAT)) u_pipe0 (
    .clk(clk), .reset(reset), .flush_i(start), .tag_i(tag0_in), .tag_o(tag0)
  );
  ra_bist_chk_pipe #(.LAT(LAT)) u_pipe1 (
    .clk(clk), .reset(reset), .flush_i(start), .tag_i(tag1_in), .tag_o(tag1)
  );

  assign diff0 = rd0_dat ^ exp_word(tag0.pat, tag0.adr);
  assign diff1 = rd1_dat ^ exp_word(tag1.pat, tag1.adr);
  assign mis0  = tag0.chk && (diff0 != {DAT_W{1'b0}});
  assign mis1  = tag1.chk && (diff1 != {DAT_W{1'b0}});
  assign sum   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, mis0} + {{CNT_W{1'b0}}, mis1};

  // Next-state: sequencing, result accumulation and first-fail capture.
  always_comb begin
    state_d = state_q;
    drn_d   = drn_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    adr_d   = adr_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    if (start) begin
      state_d = ST_RUN;
      drn_d   = 2'd0;
      fail_d  = 1'b0;
      cnt_d   = 8'd0;
      port_d  = 1'b0;
      adr_d   = 6'd0;
      ph_d    = 3'd0;
      bit_d   = 7'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (done) begin
            state_d = ST_DRAIN;
            drn_d   = 2'd0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drn_q == 2'(LAT - 1)) state_d = ST_DONE;
          else                      drn_d   = drn_q + 2'd1;
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      if (mis0 && !fail_q) begin
        port_d = 1'b0;
        adr_d  = tag0.adr;
        ph_d   = tag0.phase;
        bit_d  = low_bit(diff0);
      end else if (mis1 && !fail_q) begin
        port_d = 1'b1;
        adr_d  = tag1.adr;
        ph_d   = tag1.phase;
        bit_d  = low_bit(diff1);
      end else begin
        port_d = port_q;
      end
      fail_d = fail_q | mis0 | mis1;
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    pass_d = (state_d == ST_DONE) && !fail_d;
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drn_q   <= 2'd0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= 8'd0;
      port_q  <= 1'b0;
      adr_q   <= 6'd0;
      ph_q    <= 3'd0;
      bit_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      adr_q   <= adr_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
    end
  end

  // Pack the result registers into the status word.
  always_comb begin
    status                                = 32'd0;
    status[STS_BUSY]                      = busy_q;
    status[STS_PASS]                      = pass_q;
    status[STS_FAIL]                      = fail_q;
    status[STS_PORT]                      = port_q;
    status[STS_PH_LSB  +: PH_W]           = ph_q;
    status[STS_ADR_LSB +: ADR_W]          = adr_q;
    status[STS_BIT_LSB +: BIT_W]          = bit_q;
    status[STS_CNT_LSB +: CNT_W]          = cnt_q;
  end

  assign busy        = busy_q;
  assign bist_passed = pass_q;
  assign bist_fail   = fail_q;
  assign fail_cnt    = cnt_q;
  assign ff_port     = port_q;
  assign ff_adr      = adr_q;
  assign ff_phase    = ph_q;
  assign ff_bit      = bit_q;

endmodule

// File: tb/tb_ra_bist_chk.sv
// Randomized scoreboard bench for ra_bist_chk against a queue-based reference model.
module tb_ra_bist_chk;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, done, rd0_chk, rd1_chk;
  logic [2:0]  phase;
  logic [5:0]  rd0_adr, rd1_adr;
  logic [1:0]  rd0_pat, rd1_pat;
  logic [71:0] rd0_dat, rd1_dat;
  logic        busy, bist_fail, bist_passed, ff_port;
  logic [7:0]  fail_cnt;
  logic [5:0]  ff_adr;
  logic [2:0]  ff_phase;
  logic [6:0]  ff_bit;
  logic [31:0] status;

  ra_bist_chk #(.GENMODE(0), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .phase(phase),
    .rd0_chk(rd0_chk), .rd0_adr(rd0_adr), .rd0_pat(rd0_pat), .rd0_dat(rd0_dat),
    .rd1_chk(rd1_chk), .rd1_adr(rd1_adr), .rd1_pat(rd1_pat), .rd1_dat(rd1_dat),
    .busy(busy), .bist_fail(bist_fail), .bist_passed(bist_passed), .fail_cnt(fail_cnt),
    .ff_port(ff_port), .ff_adr(ff_adr), .ff_phase(ff_phase), .ff_bit(ff_bit), .status(status)
  );

  typedef struct {
    int         due;
    bit         port;
    logic [5:0] adr;
    logic [1:0] pat;
    logic [2:0] ph;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] expq[$];
  logic [71:0] plan0[int];
  logic [71:0] plan1[int];
  int cyc = 0;
  int n_err = 0;
  int n_chk = 0;

  // Reference model: mode 0 idle, 1 run, 2 drain, 3 done.
  int   m_mode = 0, m_left = 0, m_cnt = 0, m_bit = 0;
  bit   m_fail = 0, m_port = 0;
  logic [5:0] m_adr = 6'd0;
  logic [2:0] m_ph = 3'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [71:0] good(input logic [1:0] p, input logic [5:0] a);
    logic [71:0] w;
    for (int i = 0; i < 72; i++) begin
      case (p)
        2'd0:    w[i] = 1'b0;
        2'd1:    w[i] = 1'b1;
        2'd2:    w[i] = ((i % 2) != (a % 2));
        default: w[i] = ((i % 2) == (a % 2));
      endcase
    end
    return w;
  endfunction

  function automatic logic [71:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [71:0] bad(input logic [71:0] w);
    logic [71:0] one;
    one = 72'd1;
    return w ^ (one << $urandom_range(71, 0));
  endfunction

  function automatic logic [31:0] model_status();
    return {(m_mode == 1 || m_mode == 2), (m_mode == 3 && !m_fail), m_fail, m_port,
            m_ph, m_adr, 7'(m_bit), 8'(m_cnt), 4'h0};
  endfunction

  task automatic model_edge(input bit r, input bit st, input bit dn,
                            input bit c0, input logic [5:0] a0, input logic [1:0] p0,
                            input bit c1, input logic [5:0] a1, input logic [1:0] p1);
    pend_t keep[$];
    pend_t e;
    logic [71:0] data, w;
    int low;
    if (r || st) begin
      m_fail = 0; m_cnt = 0; m_port = 0; m_adr = 6'd0; m_ph = 3'd0; m_bit = 0;
      pend.delete();
      m_mode = r ? 0 : 1;
    end else begin
      foreach (pend[k]) begin
        if (pend[k].due == cyc) begin
          data = pend[k].port ? rd1_dat : rd0_dat;
          w = good(pend[k].pat, pend[k].adr);
          low = -1;
          for (int i = 71; i >= 0; i--) if (data[i] !== w[i]) low = i;
          if (low >= 0) begin
            if (!m_fail) begin
              m_port = pend[k].port; m_adr = pend[k].adr; m_ph = pend[k].ph; m_bit = low;
            end
            m_fail = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end else if (pend[k].due > cyc) begin
          keep.push_back(pend[k]);
        end
      end
      pend = keep;
      if (m_mode == 1) begin
        if (c0) begin e.due = cyc + LAT; e.port = 0; e.adr = a0; e.pat = p0; e.ph = phase; pend.push_back(e); end
        if (c1) begin e.due = cyc + LAT; e.port = 1; e.adr = a1; e.pat = p1; e.ph = phase; pend.push_back(e); end
      end
      if (m_mode == 1 && dn) begin
        m_mode = 2; m_left = LAT;
      end else if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) m_mode = 3;
      end
    end
    expq.push_back(model_status());
  endtask

  task automatic cycle(input bit r, input bit st, input bit dn,
                       input bit c0, input logic [5:0] a0, input logic [1:0] p0, input logic [71:0] d0,
                       input bit c1, input logic [5:0] a1, input logic [1:0] p1, input logic [71:0] d1);
    reset = r; start = st; done = dn;
    rd0_chk = c0; rd0_adr = a0; rd0_pat = p0;
    rd1_chk = c1; rd1_adr = a1; rd1_pat = p1;
    rd0_dat = plan0.exists(cyc) ? plan0[cyc] : rnd72();
    rd1_dat = plan1.exists(cyc) ? plan1[cyc] : rnd72();
    if (c0) plan0[cyc + LAT] = d0;
    if (c1) plan1[cyc + LAT] = d1;
    model_edge(r, st, dn, c0, a0, p0, c1, a1, p1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) cycle(0, 0, 0, 0, 6'd0, 2'd0, 72'd0, 0, 6'd0, 2'd0, 72'd0);
  endtask
  task automatic go();  cycle(0, 1, 0, 0, 6'd0, 2'd0, 72'd0, 0, 6'd0, 2'd0, 72'd0); endtask
  task automatic fin(); cycle(0, 0, 1, 0, 6'd0, 2'd0, 72'd0, 0, 6'd0, 2'd0, 72'd0); endtask
  task automatic rst(); cycle(1, 0, 0, 0, 6'd0, 2'd0, 72'd0, 0, 6'd0, 2'd0, 72'd0); endtask
  task automatic rd0(input logic [5:0] a, input logic [1:0] p, input logic [71:0] d);
    cycle(0, 0, 0, 1, a, p, d, 0, 6'd0, 2'd0, 72'd0);
  endtask

  // Monitor: pop the predicted status for every clock and compare both views.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      logic [31:0] e;
      e = expq.pop_front();
      check("status", status, e);
      check("fields", {busy, bist_passed, bist_fail, ff_port, ff_phase, ff_adr, ff_bit, fail_cnt, 4'h0}, e);
    end
  end

  initial begin
    logic [71:0] w, ones, p55, paa;
    logic [5:0] a0, a1;
    logic [1:0] p0, p1;
    bit c0, c1;
    ones = {72{1'b1}};
    p55 = 72'h555555555555555555;
    paa = 72'hAAAAAAAAAAAAAAAAAA;
    phase = 3'd0;
    rst(); rst();
    check("reset_status", status, 32'h0000_0000);

    // 1: clean all-zero pass
    go();
    for (int a = 0; a < 64; a++) rd0(6'(a), 2'd0, 72'd0);
    fin(); nop(1);
    check("t1_pass", status, 32'h4000_0000);

    // 2: single bit failure at 0x2A
    phase = 3'd3;
    go();
    for (int a = 0; a < 48; a++) rd0(6'(a), 2'd1, (a == 42) ? (ones & ~(72'd1 << 17)) : ones);
    fin(); nop(2);
    check("t2_ff", {16'd0, ff_port, ff_adr, ff_phase, ff_bit, fail_cnt, bist_fail, bist_passed},
          {16'd0, 1'b0, 6'h2A, 3'd3, 7'd17, 8'd1, 1'b1, 1'b0});

    // 3: dual-port same-cycle failure, port 0 wins
    phase = 3'($urandom);
    go();
    cycle(0, 0, 0, 1, 6'd5, 2'd0, bad(72'd0), 1, 6'd9, 2'd0, bad(72'd0));
    rd0(6'd7, 2'd0, 72'd0);
    rd0(6'h10, 2'd0, bad(72'd0));
    fin(); nop(2);
    check("t3_ff", {23'd0, ff_port, ff_adr, fail_cnt}, {23'd0, 1'b0, 6'd5, 8'd3});

    // 4: checkerboard / inverse checkerboard
    go();
    rd0(6'd1, 2'd2, p55);
    rd0(6'd2, 2'd2, paa);
    nop(2);
    check("t4_cb_ok", {31'd0, bist_fail}, 32'd0);
    rd0(6'd1, 2'd3, p55);
    nop(2);
    check("t4_icb", {24'd0, bist_fail, ff_bit}, {24'd0, 1'b1, 7'd0});

    // 5: saturation
    go();
    repeat (300) begin
      a0 = 6'($urandom); a1 = 6'($urandom); p0 = 2'($urandom); p1 = 2'($urandom);
      cycle(0, 0, 0, 1, a0, p0, bad(good(p0, a0)), 1, a1, p1, bad(good(p1, a1)));
    end
    fin(); nop(2);
    check("t5_sat", {24'd0, fail_cnt}, 32'd255);

    // 6: restart mid-run clears results; reset mid-drain; chk ignored in idle
    go();
    rd0(6'd3, 2'd0, bad(72'd0));
    rd0(6'd4, 2'd0, 72'd0);
    cycle(0, 1, 0, 1, 6'd6, 2'd1, 72'd0, 0, 6'd0, 2'd0, 72'd0);
    check("t6_restart", status, 32'h8000_0000);
    rd0(6'd8, 2'd0, 72'd0);
    cycle(0, 0, 1, 1, 6'd9, 2'd0, bad(72'd0), 0, 6'd0, 2'd0, 72'd0);
    rst();
    check("t6_reset", {busy, bist_passed, bist_fail, ff_port, ff_phase, ff_adr, ff_bit, fail_cnt, status[3:0]}, 32'd0);
    repeat (4) rd0(6'($urandom), 2'd0, bad(72'd0));
    nop(2);
    check("t6_idle", status, 32'd0);

    // random runs
    repeat (6) begin
      go();
      repeat ($urandom_range(60, 20)) begin
        phase = 3'($urandom);
        c0 = ($urandom % 2) == 0; c1 = ($urandom % 2) == 0;
        a0 = 6'($urandom); a1 = 6'($urandom); p0 = 2'($urandom); p1 = 2'($urandom);
        w = good(p0, a0);
        if ($urandom_range(7, 0) == 0) w = bad(w);
        cycle(($urandom_range(99, 0) == 0), ($urandom_range(49, 0) == 0), 0,
              c0, a0, p0, w, c1, a1, p1, ($urandom_range(7, 0) == 0) ? bad(good(p1, a1)) : good(p1, a1));
      end
      fin(); nop(3);
    end

    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
